// File: rtl/cpt4_driver.sv
// cpt4_driver: stimulus driver and result checker for a 4-bit comparator.
//
// A run steps through N_VECTORS operand pairs. Vector j is
// A = (5*j+4) mod 16 and B = (3*j) mod 16, built by adding 5 and 3 with
// 4-bit wrap. Each pair is held for HOLD cycles: HOLD-1 cycles in DRIVE
// while the comparator settles, then one SAMPLE cycle where Y is compared
// against the relation selected by MODE (0: A>B, 1: A==B, 2: A<B).
// Mismatches are counted in a counter that saturates at 255.
//
// Optional feature macro: CPT4_DRIVER_FAILIDX_EN
//   defined   - fail_idx captures j of the first mismatch of each run
//   undefined - fail_idx is tied to 0
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   run request pulse, honoured only in IDLE or DONE
//   A, B       out  registered comparator operands
//   Y          in   comparator result
//   busy       out  run in progress (DRIVE or SAMPLE)
//   done       out  run finished, held until next start or reset
//   pass       out  done and no mismatches
//   err_count  out  saturating mismatch count
//   fail_idx   out  index of the first mismatch (feature macro only)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | operands applied, comparator settling (HOLD-1 cycles)
// SAMPLE | one cycle: Y checked against the expected relation
// DONE   | run complete, results valid, waiting for start

module cpt4_driver #(
    parameter int N_VECTORS = 1000,
    parameter int HOLD      = 5,
    parameter int MODE      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [9:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [9:0] J_LAST    = 10'(N_VECTORS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 2);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] j;
    logic [7:0] hold_cnt;
    logic       start_ok;
    logic       hold_tc;
    logic       last_vec;
    logic       y_exp;
    logic       mismatch;

    always_comb begin
        start_ok = start && ((state == IDLE) || (state == DONE));
        hold_tc  = (hold_cnt == HOLD_LAST);
        last_vec = (j == J_LAST);
        if (MODE == 1) begin
            y_exp = (A == B);
        end else if (MODE == 2) begin
            y_exp = (A < B);
        end else begin
            y_exp = (A > B);
        end
        // Expected Y comes from the operand registers currently on the bus.
        mismatch = (state == SAMPLE) && (Y != y_exp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (hold_tc) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                state_nxt = last_vec ? DONE : DRIVE;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) begin
                    state_nxt = DRIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pass = done && (err_count == 8'd0);
    end

    // Operand generator, vector index, hold timer and error counter.
    // The hold timer counts 0..HOLD-2 in DRIVE, giving HOLD-1 drive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A         <= 4'd0;
            B         <= 4'd0;
            j         <= 10'd0;
            hold_cnt  <= 8'd0;
            err_count <= 8'd0;
        end else if (start_ok) begin
            A         <= 4'd4;
            B         <= 4'd0;
            j         <= 10'd0;
            hold_cnt  <= 8'd0;
            err_count <= 8'd0;
        end else begin
            case (state)
                DRIVE: begin
                    if (!hold_tc) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (mismatch && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (!last_vec) begin
                        j        <= j + 10'd1;
                        A        <= A + 4'd5;
                        B        <= B + 4'd3;
                        hold_cnt <= 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CPT4_DRIVER_FAILIDX_EN
    // err_count still zero at a mismatch marks the first one of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_idx <= 10'd0;
        end else if (start_ok) begin
            fail_idx <= 10'd0;
        end else if (mismatch && (err_count == 8'd0)) begin
            fail_idx <= j;
        end
    end
`else
    assign fail_idx = 10'd0;
`endif

endmodule
